// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared pipeline constants for the hazard controller: FSM state encodings,
// drain length, the scoreboard slot record and a slot lookup helper.
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  // Register-file index width and stall counter width.
  localparam int REG_W = 3;
  localparam int CNT_W = 16;

  // Controller FSM encodings, kept as plain constants so legacy code that
  // compares raw state values keeps working.
  localparam logic [1:0] RUN    = 2'h0;
  localparam logic [1:0] DRAIN  = 2'h1;
  localparam logic [1:0] HALTED = 2'h2;

  // Number of cycles HALT needs to clear the back end of the pipeline.
  localparam logic [1:0] DRAIN_CYCLES = 2'd3;

  // Saturation value of the hazard-stall counter.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // One scoreboard entry: a pending register-file write in flight.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0};

  // True when the slot holds a pending write to register r.
  function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// -----------------------------------------------------------------------------
// hazard_slot
// One scoreboard stage: a register of {valid, rd} that either captures the
// upstream entry or is cleared synchronously.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-low reset
//   clr  in   load an empty entry this cycle instead of d
//   d    in   entry from the previous stage
//   q    out  entry currently held
// -----------------------------------------------------------------------------
module hazard_slot
  import hazard_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  slot_t d,
  output slot_t q
);

  // NOTE: the slot is cleared by reset because a stale valid bit would raise
  // a phantom hazard on the very first instruction after reset.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      q <= SLOT_EMPTY;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller. Tracks pending register writes in the EX and
// MEM stages, stalls decode on a read-after-write hit, flushes on a taken
// branch, and drains the pipeline after HALT.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-low reset
//   idValid     in   decode holds a real instruction
//   idSrc1/2    in   decode source register numbers
//   idSrc1Use/2 in   corresponding source is read
//   idRegWrt    in   decode instruction writes the register file
//   idWriteReg  in   its destination register
//   idHalt      in   decode instruction is HALT
//   doBranch    in   execute resolved a taken branch/jump this cycle
//   stallPc     out  hold PC and IF/ID
//   flushId     out  load NOP into IF/ID
//   flushEx     out  load bubble into ID/EX
//   halted      out  pipeline drained after HALT
//   err         out  sticky: branch seen while draining or halted
//   stallCnt    out  saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             idValid,
  input  logic [REG_W-1:0] idSrc1,
  input  logic [REG_W-1:0] idSrc2,
  input  logic             idSrc1Use,
  input  logic             idSrc2Use,
  input  logic             idRegWrt,
  input  logic [REG_W-1:0] idWriteReg,
  input  logic             idHalt,
  input  logic             doBranch,
  output logic             stallPc,
  output logic             flushId,
  output logic             flushEx,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stallCnt
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] drain_cnt;
  logic [1:0] drain_nxt;

  slot_t ex_slot;
  slot_t mem_slot;
  slot_t ex_d;

  logic in_run;
  logic src1_hit;
  logic src2_hit;
  logic hazard;
  logic advance;
  logic halt_adv;
  logic hazard_stall;

  // ---------------------------------------------------------------------------
  // Scoreboard lookup. WB is not tracked: the register file writes through,
  // so an instruction in WB already supplies its value to decode.
  // ---------------------------------------------------------------------------
  assign src1_hit = slot_match(ex_slot, idSrc1) || slot_match(mem_slot, idSrc1);
  assign src2_hit = slot_match(ex_slot, idSrc2) || slot_match(mem_slot, idSrc2);
  assign hazard   = idValid && ((idSrc1Use && src1_hit) || (idSrc2Use && src2_hit));

  assign in_run       = (state == RUN);
  assign advance      = in_run && !hazard && !doBranch;
  assign halt_adv     = advance && idValid && idHalt;
  // Only genuine RUN-state stalls are counted; a branch flush wins over them.
  assign hazard_stall = in_run && hazard && !doBranch;

  // Entry leaving decode; a bubble or non-writing instruction carries valid=0.
  assign ex_d = '{valid: idValid && idRegWrt, rd: idWriteReg};

  // EX is emptied whenever decode does not advance (stall, flush, drain).
  hazard_slot u_ex_slot (
    .clk (clk),
    .rst (rst),
    .clr (!advance),
    .d   (ex_d),
    .q   (ex_slot)
  );

  hazard_slot u_mem_slot (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .d   (ex_slot),
    .q   (mem_slot)
  );

  // ---------------------------------------------------------------------------
  // Pipeline control outputs (combinational, same cycle as the condition).
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stallPc = 1'b0;
    flushId = 1'b0;
    flushEx = 1'b0;
    case (state)
      RUN: begin
        if (doBranch) begin
          flushId = 1'b1;
          flushEx = 1'b1;
        end else if (hazard) begin
          stallPc = 1'b1;
          flushEx = 1'b1;
        end
      end
      // DRAIN, HALTED and the unused encoding all freeze the front end; a
      // branch here is only recorded as an error.
      default: begin
        stallPc = 1'b1;
        flushEx = 1'b1;
      end
    endcase
  end

  assign halted = (state == HALTED);

  // ---------------------------------------------------------------------------
  // Next-state logic for the RUN -> DRAIN -> HALTED sequence.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (halt_adv) begin
          state_nxt = DRAIN;
          // The cycle HALT leaves decode is the first drain step, so the
          // counter starts one below DRAIN_CYCLES and halted rises exactly
          // DRAIN_CYCLES cycles after HALT advanced.
          drain_nxt = DRAIN_CYCLES - 2'd1;
        end
      end
      DRAIN: begin
        drain_nxt = drain_cnt - 2'd1;
        if (drain_cnt <= 2'd1) begin
          state_nxt = HALTED;
          drain_nxt = 2'd0;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = HALTED;
        drain_nxt = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, error flag and stall counter.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      err       <= 1'b0;
      stallCnt  <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (!in_run && doBranch) begin
        err <= 1'b1;
      end
      if (hazard_stall && (stallCnt != CNT_MAX)) begin
        stallCnt <= stallCnt + 16'd1;
      end
    end
  end

endmodule
